// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic array: FSM states, packed-index math,
// and the saturating add used when SYSTOLIC_SAT_EN is defined (supports AW up to 63).
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int SAT_W = 64;

    function automatic int elem_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    function automatic int elem_lsb(input int i, input int j, input int n, input int w);
        return elem_idx(i, j, n) * w;
    endfunction

    // Operands arrive sign-extended from aw bits, so the wide sum itself never wraps.
    function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] x,
                                                        input logic signed [SAT_W-1:0] y,
                                                        input int aw);
        logic signed [SAT_W-1:0] s, hi, lo;
        s  = x + y;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)
            return hi;
        if (s < lo)
            return lo;
        return s;
    endfunction

    function automatic logic sat_hit(input logic signed [SAT_W-1:0] x,
                                     input logic signed [SAT_W-1:0] y,
                                     input int aw);
        logic signed [SAT_W-1:0] s, hi, lo;
        s  = x + y;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: forwards a right / b down with one register per hop, accumulates a*b when both are valid.
// Accumulator restarts on the first-beat tag; saturation and sticky ovf only with SYSTOLIC_SAT_EN.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_dat,
    input  logic          a_vld,
    input  logic          a_first,
    input  logic [DW-1:0] b_dat,
    input  logic          b_vld,
    input  logic          b_first,
    output logic [DW-1:0] a_pass_dat,
    output logic          a_pass_vld,
    output logic          a_pass_first,
    output logic [DW-1:0] b_pass_dat,
    output logic          b_pass_vld,
    output logic          b_pass_first,
    output logic [AW-1:0] acc,
    output logic          ovf
);

    logic                   fire;
    logic                   first;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_x;
    logic signed [AW-1:0]   base;

    assign fire   = a_vld & b_vld;
    assign first  = a_first & b_first;
    assign prod   = $signed(a_dat) * $signed(b_dat);
    assign prod_x = AW'(prod);
    assign base   = first ? '0 : $signed(acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_pass_dat   <= '0;
            a_pass_vld   <= 1'b0;
            a_pass_first <= 1'b0;
            b_pass_dat   <= '0;
            b_pass_vld   <= 1'b0;
            b_pass_first <= 1'b0;
            acc          <= '0;
        end else begin
            a_pass_dat   <= a_dat;
            a_pass_vld   <= a_vld;
            a_pass_first <= a_first;
            b_pass_dat   <= b_dat;
            b_pass_vld   <= b_vld;
            b_pass_first <= b_first;
            if (fire) begin
`ifdef SYSTOLIC_SAT_EN
                acc <= AW'(sat_add(SAT_W'(base), SAT_W'(prod_x), AW));
`else
                acc <= base + prod_x;
`endif
            end
        end
    end

`ifdef SYSTOLIC_SAT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (fire)
            ovf <= (first ? 1'b0 : ovf) | sat_hit(SAT_W'(base), SAT_W'(prod_x), AW);
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/systolic_array_os.sv
// NxN output-stationary matmul; c_out/out_valid follow the in_last beat by 2N cycles (SYSTOLIC_SAT_EN: saturate).
// in_ready only in IDLE/LOAD; result held under out_valid until out_ready, no overlap between products.
module systolic_array_os
    import systolic_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [N*DW-1:0]   a_col,
    input  logic [N*DW-1:0]   b_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*AW-1:0] c_out,
    output logic [N*N-1:0]    ovf
);

    localparam int             CW         = $clog2(2 * N);
    localparam logic [CW-1:0]  DRAIN_LAST = CW'(2 * N - 2);

    state_t        state, state_nxt;
    logic [CW-1:0] drain_cnt;
    logic          accept;
    logic          first_beat;
    logic          drain_done;

    assign in_ready   = !rst && (state == IDLE || state == LOAD);
    assign out_valid  = !rst && (state == OUT);
    assign accept     = in_valid & in_ready;
    assign first_beat = accept & (state == IDLE);
    assign drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = in_last ? DRAIN : LOAD;
            LOAD:    if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = OUT;
            OUT:     if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Column N of a_* and row N of b_* are the unused far-edge outputs of the grid.
    logic [DW-1:0] a_link     [N][N+1];
    logic          a_vld_link [N][N+1];
    logic          a_fst_link [N][N+1];
    logic [DW-1:0] b_link     [N+1][N];
    logic          b_vld_link [N+1][N];
    logic          b_fst_link [N+1][N];
    logic [AW-1:0] acc_w      [N][N];
    logic          ovf_w      [N][N];

    // Lane i (row i of A and column i of B) is delayed i cycles so operands meet at PE(i,j) together.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_nodly
            assign a_link[0][0]     = a_col[0 +: DW];
            assign a_vld_link[0][0] = accept;
            assign a_fst_link[0][0] = first_beat;
            assign b_link[0][0]     = b_row[0 +: DW];
            assign b_vld_link[0][0] = accept;
            assign b_fst_link[0][0] = first_beat;
        end else begin : g_dly
            logic [DW-1:0] sr_a   [i];
            logic [DW-1:0] sr_b   [i];
            logic          sr_vld [i];
            logic          sr_fst [i];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        sr_a[k]   <= '0;
                        sr_b[k]   <= '0;
                        sr_vld[k] <= 1'b0;
                        sr_fst[k] <= 1'b0;
                    end
                end else begin
                    sr_a[0]   <= a_col[i*DW +: DW];
                    sr_b[0]   <= b_row[i*DW +: DW];
                    sr_vld[0] <= accept;
                    sr_fst[0] <= first_beat;
                    for (int k = 1; k < i; k++) begin
                        sr_a[k]   <= sr_a[k-1];
                        sr_b[k]   <= sr_b[k-1];
                        sr_vld[k] <= sr_vld[k-1];
                        sr_fst[k] <= sr_fst[k-1];
                    end
                end
            end

            assign a_link[i][0]     = sr_a[i-1];
            assign a_vld_link[i][0] = sr_vld[i-1];
            assign a_fst_link[i][0] = sr_fst[i-1];
            assign b_link[0][i]     = sr_b[i-1];
            assign b_vld_link[0][i] = sr_vld[i-1];
            assign b_fst_link[0][i] = sr_fst[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DW (DW),
                .AW (AW)
            ) u_pe (
                .clk          (clk),
                .rst          (rst),
                .a_dat        (a_link[i][j]),
                .a_vld        (a_vld_link[i][j]),
                .a_first      (a_fst_link[i][j]),
                .b_dat        (b_link[i][j]),
                .b_vld        (b_vld_link[i][j]),
                .b_first      (b_fst_link[i][j]),
                .a_pass_dat   (a_link[i][j+1]),
                .a_pass_vld   (a_vld_link[i][j+1]),
                .a_pass_first (a_fst_link[i][j+1]),
                .b_pass_dat   (b_link[i+1][j]),
                .b_pass_vld   (b_vld_link[i+1][j]),
                .b_pass_first (b_fst_link[i+1][j]),
                .acc          (acc_w[i][j]),
                .ovf          (ovf_w[i][j])
            );
        end
    end

    // Snapshot on the last drain cycle so the result stays put even once the next product starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_out <= '0;
            ovf   <= '0;
        end else if (drain_done) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    c_out[elem_lsb(i, j, N, AW) +: AW] <= acc_w[i][j];
                    ovf[elem_idx(i, j, N)]             <= ovf_w[i][j];
                end
            end
        end
    end

endmodule
